// File: rtl/agu_pkg.sv
// agu_pkg: shared widths, FSM encoding and helpers for the strided AGU.
// Optional alignment check in agu_stream is enabled by AGU_ALIGN_CHECK_EN.
package agu_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int IMM_W_DEF  = 16;
  localparam int CNT_W_DEF  = 8;
  localparam int LANES_DEF  = 4;
  localparam int MAX_W      = 64;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Widen the low w bits of v; callers cast the result to their width.
  function automatic logic [MAX_W-1:0] ext(
    input logic [MAX_W-1:0] v,
    input int               w,
    input logic             zext
  );
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++)
      r[i] = (i < w) ? v[i] : (~zext & v[w-1]);
    return r;
  endfunction

  function automatic logic [MAX_W-1:0] lane_mask(
    input logic [31:0] rem,
    input int          lanes
  );
    logic [MAX_W-1:0] m;
    m = '0;
    for (int k = 0; k < MAX_W; k++)
      m[k] = (k < lanes) && (32'(k) < rem);
    return m;
  endfunction

endpackage

// File: rtl/agu_lane_gen.sv
// agu_lane_gen: per-lane strided addresses for one beat.
// Inactive lanes are forced to zero.
module agu_lane_gen
  import agu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LANES  = LANES_DEF
) (
  input  logic [DATA_W-1:0]       cur,
  input  logic [DATA_W-1:0]       stride,
  input  logic [LANES-1:0]        mask,
  output logic [LANES*DATA_W-1:0] addr
);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign addr[k*DATA_W +: DATA_W] =
      mask[k] ? cur + DATA_W'(k) * stride : '0;
  end

endmodule

// File: rtl/agu_stream.sv
// agu_stream: pipelined strided address stream, LANES addresses per beat.
// Define AGU_ALIGN_CHECK_EN to add ALIGN_LOG2 and the misalign_o flag.
module agu_stream
  import agu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IMM_W  = IMM_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int LANES  = LANES_DEF
`ifdef AGU_ALIGN_CHECK_EN
  , parameter int ALIGN_LOG2 = 2
`endif
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [DATA_W-1:0]       base_i,
  input  logic [IMM_W-1:0]        immd_i,
  input  logic                    zext_i,
  input  logic [IMM_W-1:0]        stride_i,
  input  logic [CNT_W-1:0]        count_i,
  output logic                    addr_valid_o,
  input  logic                    addr_ready_i,
  output logic [LANES*DATA_W-1:0] addr_o,
  output logic [LANES-1:0]        lane_mask_o,
  output logic                    last_o,
  output logic                    busy_o
`ifdef AGU_ALIGN_CHECK_EN
  , output logic                  misalign_o
`endif
);

  state_t state, state_nx;

  logic [DATA_W-1:0] cur_q, stride_q;
  logic [CNT_W-1:0]  rem_q;

  logic [DATA_W-1:0] cur_s, stride_s, step_s;
  logic [CNT_W-1:0]  rem_s;
  logic [LANES-1:0]  mask_s;
  logic              last_s;
  logic [LANES*DATA_W-1:0] lane_addr;

  logic accept, advance, load;

  assign req_ready_o = (state == IDLE);
  assign busy_o      = (state == RUN);

  // RUN always presents a valid beat, so ready alone completes it.
  assign accept  = (state == IDLE) && req_valid_i;
  assign advance = (state == RUN) && addr_ready_i;
  assign load    = (accept && count_i != '0) || (advance && !last_o);

  // Accept computes the first beat straight from the request inputs.
  always_comb begin
    cur_s    = cur_q;
    stride_s = stride_q;
    rem_s    = rem_q;
    if (state == IDLE) begin
      cur_s    = base_i
               + DATA_W'(ext(MAX_W'(immd_i), IMM_W, zext_i));
      stride_s = DATA_W'(ext(MAX_W'(stride_i), IMM_W, 1'b0));
      rem_s    = count_i;
    end
  end

  assign mask_s = LANES'(lane_mask(32'(rem_s), LANES));
  assign last_s = 32'(rem_s) <= 32'(LANES);
  assign step_s = DATA_W'(LANES) * stride_s;

  agu_lane_gen #(
    .DATA_W (DATA_W),
    .LANES  (LANES)
  ) u_lane_gen (
    .cur    (cur_s),
    .stride (stride_s),
    .mask   (mask_s),
    .addr   (lane_addr)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (req_valid_i && count_i != '0) state_nx = RUN;
      RUN:  if (addr_ready_i && last_o)       state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state        <= IDLE;
      cur_q        <= '0;
      stride_q     <= '0;
      rem_q        <= '0;
      addr_valid_o <= 1'b0;
      addr_o       <= '0;
      lane_mask_o  <= '0;
      last_o       <= 1'b0;
    end else begin
      state <= state_nx;
      if (load) begin
        cur_q        <= cur_s + step_s;
        stride_q     <= stride_s;
        rem_q        <= last_s ? '0 : rem_s - CNT_W'(LANES);
        addr_valid_o <= 1'b1;
        addr_o       <= lane_addr;
        lane_mask_o  <= mask_s;
        last_o       <= last_s;
      end else if (advance) begin
        addr_valid_o <= 1'b0;
        addr_o       <= '0;
        lane_mask_o  <= '0;
        last_o       <= 1'b0;
      end
    end
  end

`ifdef AGU_ALIGN_CHECK_EN
  logic mis_s;

  always_comb begin
    mis_s = 1'b0;
    for (int k = 0; k < LANES; k++)
      if (mask_s[k] && lane_addr[k*DATA_W +: ALIGN_LOG2] != '0)
        mis_s = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i)     misalign_o <= 1'b0;
    else if (load)    misalign_o <= mis_s;
    else if (advance) misalign_o <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_agu_stream.sv
// tb_agu_stream: vector table plus scoreboard for agu_stream.
// Build with AGU_ALIGN_CHECK_EN to include the misalign checks.
module tb_agu_stream;
  import agu_pkg::*;

  localparam int DW = 32;
  localparam int IW = 16;
  localparam int CW = 8;
  localparam int L  = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          req_valid, req_valid1;
  logic          req_ready, req_ready1;
  logic [DW-1:0] base;
  logic [IW-1:0] immd, stride;
  logic          zext;
  logic [CW-1:0] count;
  logic          addr_valid, addr_ready, last, busy;
  logic [L*DW-1:0] addr;
  logic [L-1:0]  mask;
  logic          addr_valid1, last1, busy1;
  logic [DW-1:0] addr1;
  logic [0:0]    mask1;
`ifdef AGU_ALIGN_CHECK_EN
  logic          misalign, misalign1;
`endif

  agu_stream #(.DATA_W(DW), .IMM_W(IW), .CNT_W(CW), .LANES(L)) u_dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .base_i       (base),
    .immd_i       (immd),
    .zext_i       (zext),
    .stride_i     (stride),
    .count_i      (count),
    .addr_valid_o (addr_valid),
    .addr_ready_i (addr_ready),
    .addr_o       (addr),
    .lane_mask_o  (mask),
    .last_o       (last),
    .busy_o       (busy)
`ifdef AGU_ALIGN_CHECK_EN
    , .misalign_o (misalign)
`endif
  );

  agu_stream #(.DATA_W(DW), .IMM_W(IW), .CNT_W(CW), .LANES(1)) u_dut1 (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .req_valid_i  (req_valid1),
    .req_ready_o  (req_ready1),
    .base_i       (base),
    .immd_i       (immd),
    .zext_i       (zext),
    .stride_i     (stride),
    .count_i      (count),
    .addr_valid_o (addr_valid1),
    .addr_ready_i (1'b1),
    .addr_o       (addr1),
    .lane_mask_o  (mask1),
    .last_o       (last1),
    .busy_o       (busy1)
`ifdef AGU_ALIGN_CHECK_EN
    , .misalign_o (misalign1)
`endif
  );

  typedef struct {
    logic [L*DW-1:0] addr;
    logic [L-1:0]    mask;
    logic            last;
  } beat_t;

  typedef struct {
    logic [DW-1:0] base;
    logic [IW-1:0] immd;
    logic          zext;
    logic [IW-1:0] stride;
    logic [CW-1:0] count;
    int            stall;
    logic [DW-1:0] a0;
    logic [DW-1:0] a1;
    int            beats;
  } vec_t;

  beat_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  function automatic void chk(string nm, logic [127:0] act,
                              logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Reference: each lane address computed from its element index.
  task automatic push_model(input logic [DW-1:0] b, input logic [IW-1:0] i,
                            input logic z, input logic [IW-1:0] s,
                            input logic [CW-1:0] c);
    logic [DW-1:0] s0, st;
    int nb;
    beat_t bt;
    s0 = b + (z ? {16'h0, i} : {{16{i[15]}}, i});
    st = {{16{s[15]}}, s};
    nb = (int'(c) + L - 1) / L;
    for (int bi = 0; bi < nb; bi++) begin
      bt.addr = '0;
      bt.mask = '0;
      bt.last = (bi == nb - 1);
      for (int k = 0; k < L; k++) begin
        int idx;
        idx = bi * L + k;
        if (idx < int'(c)) begin
          bt.mask[k] = 1'b1;
          bt.addr[k*DW +: DW] = s0 + DW'(idx) * st;
        end
      end
      exp_q.push_back(bt);
    end
  endtask

  task automatic send(input bit which, input logic [DW-1:0] b,
                      input logic [IW-1:0] i, input logic z,
                      input logic [IW-1:0] s, input logic [CW-1:0] c);
    int w;
    logic rdy;
    w = 0;
    rdy = which ? req_ready1 : req_ready;
    while (!rdy && w < 100) begin
      @(negedge clk);
      w++;
      rdy = which ? req_ready1 : req_ready;
    end
    chk("req_ready_wait", rdy, 1);
    base = b; immd = i; zext = z; stride = s; count = c;
    if (which) req_valid1 = 1'b1;
    else begin
      req_valid = 1'b1;
      push_model(b, i, z, s, c);
    end
    @(negedge clk);
    req_valid = 1'b0;
    req_valid1 = 1'b0;
    base = $urandom; immd = IW'($urandom); stride = IW'($urandom);
    count = CW'($urandom); zext = 1'($urandom);
  endtask

  task automatic drain(input int stall, output logic [L*DW-1:0] first,
                       output int beats);
    int cyc;
    bit held;
    beat_t hb, e;
    cyc = 0; held = 0; beats = 0; first = '0;
    while (exp_q.size() > 0 && cyc < 400) begin
      addr_ready = ($urandom_range(99) >= stall);
      if (held) begin
        chk("hold_valid", addr_valid, 1);
        chk("hold_addr", addr, hb.addr);
        chk("hold_mask", mask, hb.mask);
        chk("hold_last", last, hb.last);
        held = 0;
      end
      if (addr_valid) begin
        if (addr_ready) begin
          e = exp_q.pop_front();
          chk("beat_addr", addr, e.addr);
          chk("beat_mask", mask, e.mask);
          chk("beat_last", last, e.last);
          if (beats == 0) first = addr;
          beats++;
        end else begin
          held = 1;
          hb.addr = addr; hb.mask = mask; hb.last = last;
        end
      end
      @(negedge clk);
      cyc++;
    end
    chk("drain_done", exp_q.size(), 0);
    chk("bubble_valid", addr_valid, 0);
    chk("bubble_busy", busy, 0);
  endtask

  vec_t tv[8];
  logic [L*DW-1:0] fb;
  int nb;

  initial begin
    tv[0] = '{32'h100, 16'h0, 1'b0, 16'h4, 8'd6, 0,
              32'h100, 32'h104, 2};
    tv[1] = '{32'h1000, 16'hFFFC, 1'b1, 16'h4, 8'd1, 0,
              32'h0001_0FFC, 32'h0, 1};
    tv[2] = '{32'hFFFF_FFFC, 16'h0, 1'b0, 16'h4, 8'd4, 10,
              32'hFFFF_FFFC, 32'h0, 1};
    tv[3] = '{32'h40, 16'h0, 1'b0, 16'hFFF8, 8'd4, 0,
              32'h40, 32'h38, 1};
    tv[4] = '{32'h200, 16'h0, 1'b0, 16'h0, 8'd9, 25,
              32'h200, 32'h200, 3};
    tv[5] = '{32'h1000, 16'hFFFC, 1'b0, 16'h8, 8'd8, 50,
              32'h0FFC, 32'h1004, 2};
    tv[6] = '{32'h0, 16'h7FFF, 1'b0, 16'h1, 8'd255, 30,
              32'h7FFF, 32'h8000, 64};
    tv[7] = '{32'h10, 16'h8000, 1'b0, 16'h8000, 8'd5, 20,
              32'hFFFF_8010, 32'hFFFF_0010, 2};

    rst_n = 1'b0; req_valid = 0; req_valid1 = 0; addr_ready = 1'b1;
    base = '0; immd = '0; zext = 0; stride = '0; count = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", addr_valid, 0);
    chk("rst_addr", addr, 0);
    chk("rst_mask", mask, 0);
    chk("rst_last", last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Legacy single-lane equivalence.
    send(1, 32'h1000, 16'hFFFC, 1'b0, 16'h4, 8'd1);
    chk("legacy_valid", addr_valid1, 1);
    chk("legacy_addr", addr1, 32'h0FFC);
    chk("legacy_mask", mask1, 1);
    chk("legacy_last", last1, 1);
    @(negedge clk);
    chk("legacy_done", addr_valid1, 0);

    for (int v = 0; v < 8; v++) begin
      send(0, tv[v].base, tv[v].immd, tv[v].zext, tv[v].stride,
           tv[v].count);
      drain(tv[v].stall, fb, nb);
      chk($sformatf("tv%0d_a0", v), fb[31:0], tv[v].a0);
      chk($sformatf("tv%0d_a1", v), fb[63:32], tv[v].a1);
      chk($sformatf("tv%0d_beats", v), nb, tv[v].beats);
    end

    // Backpressure with negative stride.
    addr_ready = 1'b0;
    send(0, 32'h40, 16'h0, 1'b0, 16'hFFF8, 8'd4);
    repeat (3) begin
      chk("bp_valid", addr_valid, 1);
      chk("bp_addr", addr, {32'h28, 32'h30, 32'h38, 32'h40});
      chk("bp_mask", mask, 4'hF);
      chk("bp_last", last, 1);
      @(negedge clk);
    end
    drain(0, fb, nb);

    // Zero-count request.
    send(0, 32'h500, 16'h0, 1'b0, 16'h4, 8'd0);
    repeat (3) begin
      chk("cnt0_valid", addr_valid, 0);
      chk("cnt0_ready", req_ready, 1);
      chk("cnt0_busy", busy, 0);
      @(negedge clk);
    end

    // Reset in the middle of a stream.
    addr_ready = 1'b0;
    send(0, 32'h0, 16'h0, 1'b0, 16'h4, 8'd20);
    @(negedge clk);
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_valid", addr_valid, 0);
    chk("mrst_addr", addr, 0);
    chk("mrst_mask", mask, 0);
    chk("mrst_last", last, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_ready", req_ready, 1);
    rst_n = 1'b1;
    exp_q.delete();
    addr_ready = 1'b1;
    @(negedge clk);
    chk("mrst_quiet", addr_valid, 0);

`ifdef AGU_ALIGN_CHECK_EN
    addr_ready = 1'b0;
    send(0, 32'h102, 16'h0, 1'b0, 16'h4, 8'd4);
    chk("mis_hi", misalign, 1);
    drain(0, fb, nb);
    addr_ready = 1'b0;
    send(0, 32'h100, 16'h0, 1'b0, 16'h1, 8'd1);
    chk("mis_inactive", misalign, 0);
    drain(0, fb, nb);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/agu_stream.md
Name: agu_stream

Overview:
- Parametrised, pipelined successor to the single-shot address generation unit in the SIMD pipeline.
- Accepts one request (base, immediate offset, stride, element count) and emits a strided address stream, LANES addresses per beat, to the SIMD load/store unit.
- Uses a valid/ready handshake on both sides.
- With LANES=1 and count=1, the single beat equals base + sign-extended immediate, the legacy result.

Parameters:
- DATA_W, 32, address/data width.
- IMM_W, 16, immediate and stride width.
- CNT_W, 8, element-count width.
- LANES, 4, addresses emitted per beat (>=1).

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  synchronous active-low reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when high with req_valid_i.
- base_i  in  DATA_W  base register value.
- immd_i  in  IMM_W  immediate offset.
- zext_i  in  1  1 = zero-extend immd_i, 0 = sign-extend (legacy).
- stride_i  in  IMM_W  signed element stride in bytes, always sign-extended.
- count_i  in  CNT_W  number of elements.
- addr_valid_o  out  1  beat valid.
- addr_ready_i  in  1  consumer accepts beat.
- addr_o  out  LANES*DATA_W  lane k address in bits [k*DATA_W +: DATA_W].
- lane_mask_o  out  LANES  active lanes of beat.
- last_o  out  1  final beat of request.
- busy_o  out  1  request in progress.

Behaviour:
- Clock and reset: single clock. Reset is synchronous and active-low on rst_n_i and wins over every other input, including mid-stream, where it drops the stream with no last_o.
- Reset values: state=IDLE, addr_valid_o=0, addr_o=0, lane_mask_o=0, last_o=0, busy_o=0, internal cur/remaining=0.
- States:
  - IDLE: req_ready_o=1, busy_o=0.
  - RUN: req_ready_o=0, busy_o=1.
- Accept (IDLE and req_valid_i):
  - cur = base_i + ext(immd_i), where ext is sign- or zero-extension per zext_i.
  - rem = count_i.
  - If count_i=0: no beat is emitted and the block stays IDLE.
  - Otherwise go to RUN.
- First beat timing: addr_valid_o rises the cycle after acceptance. All outputs are registered.
- Beat contents:
  - Lane k address = cur + k*sext(stride_i).
  - lane_mask_o bit k = (k < min(rem, LANES)). Addresses of inactive lanes are driven 0.
  - last_o = (rem <= LANES).
- Holding: while addr_valid_o && !addr_ready_i, all beat outputs are held stable.
- Beat handshake (addr_valid_o && addr_ready_i):
  - cur += LANES*sext(stride_i); stride is captured at accept.
  - rem -= LANES.
  - The next beat is presented the following cycle, or the block returns to IDLE if last_o was set. Result: one bubble cycle between requests.
- Arithmetic:
  - All additions are modulo 2^DATA_W; wrap-around is silent.
  - Negative strides produce descending addresses.
  - Stride 0 repeats the same address in every active lane.
- Request inputs are sampled only at accept; changes during RUN are ignored.

Optional Feature:
- Macro: AGU_ALIGN_CHECK_EN.
- When defined:
  - Adds parameter ALIGN_LOG2 (default 2) and output port misalign_o (1 bit, reset 0).
  - misalign_o is registered with each beat and is high if any active lane address has a nonzero value in bits [ALIGN_LOG2-1:0].
  - Inactive lanes are never flagged.
- When undefined: no port and no logic.

Decomposition:
- Package agu_pkg:
  - Default width constants.
  - State encoding (IDLE/RUN).
  - Extension function ext(value, zext) to DATA_W.
  - Function computing the lane mask from rem.
- One sub-module, agu_lane_gen: combinational, takes cur, stride, and mask and produces the LANES addresses. Instantiated once; the top holds the FSM and registers.

Test Plan:
- Legacy equivalence (LANES=1): base=0x1000, immd=0xFFFC, zext=0, count=1 -> one beat addr=0x0FFC, mask=1, last=1.
- Zero-extend: base=0x1000, immd=0xFFFC, zext=1 -> first addr=0x00010FFC.
- Partial final beat (LANES=4): base=0x100, immd=0, stride=4, count=6.
  - Beat 1: 0x100,0x104,0x108,0x10C, mask=1111, last=0.
  - Beat 2: 0x110,0x114,0,0, mask=0011, last=1.
- Backpressure and negative stride: hold addr_ready_i=0 for 3 cycles with stride=0xFFF8 (-8), base=0x40.
  - Outputs stay stable while stalled.
  - Beat lanes are 0x40,0x38,0x30,0x28.
- Boundaries:
  - count=0: accepted, no addr_valid_o, req_ready_o stays high.
  - base=0xFFFFFFFC, stride=4: lane 1 wraps to 0x00000000.
  - rst_n_i=0 mid-RUN: next cycle IDLE, all outputs at reset values.
- AGU_ALIGN_CHECK_EN, ALIGN_LOG2=2, base=0x102, stride=4: misalign_o=1 on the first beat.
